cache_control: RTL and testbench
================================

# cache_control

Control FSM for the 2-way set-associative, write-back, write-allocate L1 cache. It sequences the per-way data arrays, tag/valid/dirty arrays and the LRU array, arbitrates between CPU hits and line fills/writebacks to physical memory, and maintains hit/miss/writeback counters. It is purely control: all arrays and address muxing live in the cache datapath, and this block drives their load/select strobes from datapath status.

## Interface
Parameters:
- s_offset, 5, log2 line bytes; line = 256 bits, byte mask width 2**s_offset = 32
- cnt_width, 32, width of each performance counter

Ports:
- clk  in  1  clock; all state changes on rising edge
- rst  in  1  synchronous, active-high reset
- mem_read  in  1  CPU read request; held stable until mem_resp
- mem_write  in  1  CPU write request; held stable until mem_resp
- hit  in  2  per-way tag match AND valid, from registered array outputs
- lru  in  1  LRU bit of the addressed set (way to evict)
- victim_valid  in  1  valid bit of way `lru`
- victim_dirty  in  1  dirty bit of way `lru`
- pmem_resp  in  1  physical-memory completion, one-cycle pulse
- mem_resp  out  1  CPU completion, one-cycle pulse
- pmem_read  out  1  line read request to physical memory
- pmem_write  out  1  line write request to physical memory
- pmem_addr_sel  out  1  0 = {cpu tag, index}, 1 = {victim tag, index}
- way_sel  out  1  way targeted by data/tag/dirty writes this cycle
- data_we  out  1  write-enable for way way_sel; datapath forms byte mask (full for fill, mem_byte_enable-based for CPU write)
- data_src  out  1  0 = CPU write data, 1 = pmem line
- tag_load, valid_load, dirty_load  out  1 each  load strobes for way way_sel
- dirty_in  out  1  value for dirty_load
- lru_load, lru_in  out  1 each  LRU update strobe and value
- hit_count, miss_count, wb_count  out  cnt_width  performance counters

## Operation
- States: IDLE, COMPARE, WRITEBACK, FILL, REREAD. All outputs Moore/decoded from state + current inputs, combinational; every output 0 except counters in IDLE.
- IDLE: if mem_read|mem_write → COMPARE (arrays read index this edge; registered outputs valid in COMPARE).
- COMPARE, hit != 0: w = hit[1] ? 1 : 0. mem_resp=1; lru_load=1, lru_in=~w; on write also way_sel=w, data_we=1, data_src=0, dirty_load=1, dirty_in=1. hit_count++. → IDLE.
- COMPARE, miss: miss_count++; way_sel=lru. If victim_valid & victim_dirty → WRITEBACK, else → FILL.
- WRITEBACK: pmem_write=1, pmem_addr_sel=1, way_sel=lru; hold until pmem_resp; on pmem_resp wb_count++ → FILL.
- FILL: pmem_read=1, pmem_addr_sel=0, way_sel=lru; on pmem_resp: data_we=1, data_src=1, tag_load=1, valid_load=1, dirty_load=1, dirty_in=0 → REREAD.
- REREAD: no strobes; one cycle for arrays to re-read → COMPARE (now guaranteed hit; counts as hit as well — hit_count increments on refetched access, miss_count counted once).
- mem_read and mem_write both high: treated as write.
- hit == 2'b11 (illegal): way 1 chosen.
- pmem_resp in IDLE/COMPARE/REREAD ignored.
- Counters saturate at all-ones, no wrap.

## Timing
- Reset: state=IDLE, all three counters 0, all other outputs 0 the cycle after rst sampled high. Reset mid-WRITEBACK/FILL drops pmem_read/pmem_write immediately next cycle; no array strobes issued.
- Hit latency: request seen in cycle 0 (IDLE), mem_resp in cycle 1.
- Clean miss: mem_resp = 4 + pmem latency cycles after request (IDLE, COMPARE, FILL…, REREAD, COMPARE).
- Dirty miss: adds WRITEBACK duration; pmem_read never asserted before WRITEBACK's pmem_resp.
- pmem_read/pmem_write stay high, with stable pmem_addr_sel, through the pmem_resp cycle, then drop.
- mem_resp never high for two consecutive cycles.

## Test plan
- Read hit way 1 (hit=2'b10): request cycle 0 → mem_resp cycle 1, lru_load=1, lru_in=0, hit_count=1, no pmem activity.
- Write hit way 0: → data_we=1, data_src=0, way_sel=0, dirty_load=1, dirty_in=1, lru_in=1 in same cycle as mem_resp.
- Clean miss, lru=1, pmem_resp after 5 cycles: → FILL strobes way 1 with dirty_in=0, REREAD, hit COMPARE; miss_count=1, hit_count=1, wb_count=0.
- Dirty miss: pmem_write with pmem_addr_sel=1 until resp, then pmem_read with sel=0; wb_count=1; never both pmem strobes high.
- rst asserted during FILL: next cycle pmem_read=0, counters 0, no tag/valid load.
- Drive miss_count to all-ones via forced state, another miss → stays all-ones.

Source files
------------

// File: rtl/cache_control.sv
// cache_control
//   Control FSM for the 2-way set-associative, write-back, write-allocate L1
//   cache. It sequences the data, tag/valid/dirty and LRU array strobes from
//   datapath status. It also arbitrates CPU hits against line fills and
//   writebacks, and keeps saturating hit/miss/writeback counters.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   mem_read, mem_write      CPU request, held until mem_resp (both = write)
//   hit[1:0]                 per-way tag match & valid (registered arrays)
//   lru                      way to evict in the addressed set
//   victim_valid/dirty       valid/dirty bits of way lru
//   pmem_resp                physical-memory completion pulse
//   mem_resp                 CPU completion pulse
//   pmem_read, pmem_write    line requests to physical memory
//   pmem_addr_sel            0 = {cpu tag, index}, 1 = {victim tag, index}
//   way_sel                  way targeted by data/tag/dirty writes
//   data_we, data_src        data write enable; 0 = CPU data, 1 = pmem line
//   tag_load, valid_load     tag/valid load strobes for way_sel
//   dirty_load, dirty_in     dirty load strobe and value
//   lru_load, lru_in         LRU update strobe and value
//   hit_count, miss_count,
//   wb_count                 saturating performance counters
module cache_control #(
  parameter int unsigned s_offset  = 5,
  parameter int unsigned cnt_width = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 mem_read,
  input  logic                 mem_write,
  input  logic [1:0]           hit,
  input  logic                 lru,
  input  logic                 victim_valid,
  input  logic                 victim_dirty,
  input  logic                 pmem_resp,
  output logic                 mem_resp,
  output logic                 pmem_read,
  output logic                 pmem_write,
  output logic                 pmem_addr_sel,
  output logic                 way_sel,
  output logic                 data_we,
  output logic                 data_src,
  output logic                 tag_load,
  output logic                 valid_load,
  output logic                 dirty_load,
  output logic                 dirty_in,
  output logic                 lru_load,
  output logic                 lru_in,
  output logic [cnt_width-1:0] hit_count,
  output logic [cnt_width-1:0] miss_count,
  output logic [cnt_width-1:0] wb_count
);

  // The datapath is built around 256-bit lines; any other geometry is a
  // configuration error.
  if (s_offset != 5) begin : g_bad_line
    $error("cache_control: unsupported s_offset");
  end

  typedef enum logic [2:0] {
    IDLE,
    COMPARE,
    WRITEBACK,
    FILL,
    REREAD
  } state_t;

  state_t state;

  // hit == 2'b11 cannot legally occur; way 1 wins if it does.
  logic hit_way;
  assign hit_way = hit[1];

  function automatic logic [cnt_width-1:0] sat_inc(input logic [cnt_width-1:0] v);
    return (v == '1) ? v : v + cnt_width'(1);
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      hit_count  <= '0;
      miss_count <= '0;
      wb_count   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (mem_read | mem_write) state <= COMPARE;
        end
        COMPARE: begin
          if (|hit) begin
            // The compare after a refill counts as a hit too.
            hit_count <= sat_inc(hit_count);
            state     <= IDLE;
          end else begin
            miss_count <= sat_inc(miss_count);
            state      <= (victim_valid & victim_dirty) ? WRITEBACK : FILL;
          end
        end
        WRITEBACK: begin
          if (pmem_resp) begin
            wb_count <= sat_inc(wb_count);
            state    <= FILL;
          end
        end
        FILL: begin
          if (pmem_resp) state <= REREAD;
        end
        REREAD: begin
          state <= COMPARE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    mem_resp      = 1'b0;
    pmem_read     = 1'b0;
    pmem_write    = 1'b0;
    pmem_addr_sel = 1'b0;
    way_sel       = 1'b0;
    data_we       = 1'b0;
    data_src      = 1'b0;
    tag_load      = 1'b0;
    valid_load    = 1'b0;
    dirty_load    = 1'b0;
    dirty_in      = 1'b0;
    lru_load      = 1'b0;
    lru_in        = 1'b0;
    case (state)
      COMPARE: begin
        if (|hit) begin
          mem_resp = 1'b1;
          lru_load = 1'b1;
          lru_in   = ~hit_way;
          if (mem_write) begin
            way_sel    = hit_way;
            data_we    = 1'b1;
            dirty_load = 1'b1;
            dirty_in   = 1'b1;
          end
        end else begin
          way_sel = lru;
        end
      end
      WRITEBACK: begin
        pmem_write    = 1'b1;
        pmem_addr_sel = 1'b1;
        way_sel       = lru;
      end
      FILL: begin
        pmem_read = 1'b1;
        way_sel   = lru;
        if (pmem_resp) begin
          data_we    = 1'b1;
          data_src   = 1'b1;
          tag_load   = 1'b1;
          valid_load = 1'b1;
          dirty_load = 1'b1;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_cache_control.sv
module tb_cache_control;
  localparam int unsigned CW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          mem_read, mem_write;
  logic [1:0]    hit;
  logic          lru, victim_valid, victim_dirty, pmem_resp;
  logic          mem_resp, pmem_read, pmem_write, pmem_addr_sel, way_sel;
  logic          data_we, data_src, tag_load, valid_load, dirty_load, dirty_in;
  logic          lru_load, lru_in;
  logic [CW-1:0] hit_count, miss_count, wb_count;

  cache_control #(.s_offset(5), .cnt_width(CW)) dut (
    .clk(clk), .rst(rst), .mem_read(mem_read), .mem_write(mem_write),
    .hit(hit), .lru(lru), .victim_valid(victim_valid), .victim_dirty(victim_dirty),
    .pmem_resp(pmem_resp), .mem_resp(mem_resp), .pmem_read(pmem_read),
    .pmem_write(pmem_write), .pmem_addr_sel(pmem_addr_sel), .way_sel(way_sel),
    .data_we(data_we), .data_src(data_src), .tag_load(tag_load),
    .valid_load(valid_load), .dirty_load(dirty_load), .dirty_in(dirty_in),
    .lru_load(lru_load), .lru_in(lru_in), .hit_count(hit_count),
    .miss_count(miss_count), .wb_count(wb_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rd;
    logic        wr;
    logic [1:0]  hit;
    logic        lru;
    logic        vv;
    logic        vd;
    int unsigned wb_lat;    // WRITEBACK cycles before the resp cycle
    int unsigned fill_lat;  // FILL cycles before the resp cycle
    int unsigned exp_cyc;   // cycle of mem_resp, request cycle = 0
    logic        exp_way;
  } vec_t;

  typedef struct {
    int unsigned cyc;
    logic        way;
    logic        wr;
  } exp_t;

  exp_t          sb[$];
  vec_t          tbl[8];
  int            checks = 0;
  int            failures = 0;
  logic [CW-1:0] m_hit, m_miss, m_wb;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [CW-1:0] sat(input logic [CW-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

  task automatic chk_counters(input string name);
    chk({name, "_hit_count"},  32'(hit_count),  32'(m_hit));
    chk({name, "_miss_count"}, 32'(miss_count), 32'(m_miss));
    chk({name, "_wb_count"},   32'(wb_count),   32'(m_wb));
  endtask

  task automatic chk_idle(input string name);
    chk({name, "_outputs_zero"},
        32'({mem_resp, pmem_read, pmem_write, pmem_addr_sel, way_sel, data_we,
             data_src, tag_load, valid_load, dirty_load, dirty_in, lru_load, lru_in}),
        32'd0);
  endtask

  // Entered and left at posedge+1; plays CPU and physical memory.
  task automatic run_txn(input vec_t v, input string name);
    int unsigned cyc = 0;
    int unsigned wb_n = 0;
    int unsigned fill_n = 0;
    bit          wb_done = 0;
    bit          fill_done = 0;
    bit          got = 0;
    bit          prev_resp = 0;
    bit          dirty_victim;
    exp_t        e;
    dirty_victim = v.vv & v.vd;
    mem_read = v.rd; mem_write = v.wr; hit = v.hit; lru = v.lru;
    victim_valid = v.vv; victim_dirty = v.vd; pmem_resp = 0;
    sb.push_back('{v.exp_cyc, v.exp_way, v.wr});
    while (!got && cyc < 60) begin
      pmem_resp = 0;
      if (pmem_write) begin
        wb_n++;
        if (wb_n == v.wb_lat + 1) pmem_resp = 1;
      end else if (pmem_read) begin
        fill_n++;
        if (fill_n == v.fill_lat + 1) pmem_resp = 1;
      end
      @(negedge clk);
      chk({name, "_pmem_excl"}, 32'(pmem_read & pmem_write), 32'd0);
      chk({name, "_resp_consec"}, 32'(prev_resp & mem_resp), 32'd0);
      prev_resp = mem_resp;
      if (pmem_write) begin
        chk({name, "_wb_sel"}, 32'({pmem_addr_sel, way_sel, data_we}), 32'({1'b1, v.lru, 1'b0}));
        if (pmem_resp) wb_done = 1;
      end
      if (pmem_read) begin
        chk({name, "_rd_order"}, 32'(wb_done), 32'(dirty_victim));
        chk({name, "_rd_sel"}, 32'({pmem_addr_sel, way_sel}), 32'({1'b0, v.lru}));
        if (pmem_resp) begin
          chk({name, "_fill_strobes"},
              32'({data_we, data_src, tag_load, valid_load, dirty_load, dirty_in, way_sel}),
              32'({6'b111110, v.lru}));
          fill_done = 1;
        end
      end
      if (mem_resp) begin
        got = 1;
        if (sb.size() == 0) begin
          chk({name, "_sb_empty"}, 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          chk({name, "_latency"}, cyc, e.cyc);
          chk({name, "_lru"}, 32'({lru_load, lru_in}), 32'({1'b1, ~e.way}));
          if (e.wr)
            chk({name, "_wr_strobes"},
                32'({way_sel, data_we, data_src, dirty_load, dirty_in, tag_load}),
                32'({e.way, 5'b10110}));
          else
            chk({name, "_rd_strobes"}, 32'({data_we, dirty_load, tag_load}), 32'd0);
        end
      end else if (!(pmem_read && pmem_resp)) begin
        chk({name, "_no_strobes"},
            32'({data_we, tag_load, valid_load, dirty_load, lru_load}), 32'd0);
      end
      @(posedge clk); #1;
      cyc++;
      if (fill_done) hit = v.lru ? 2'b10 : 2'b01;
    end
    if (!got) begin
      chk({name, "_timeout"}, 32'd0, 32'd1);
      if (sb.size() != 0) void'(sb.pop_front());
    end
    mem_read = 0; mem_write = 0; hit = 0; pmem_resp = 0;
    if (v.hit != 2'b00) begin
      m_hit = sat(m_hit);
    end else begin
      m_miss = sat(m_miss);
      if (dirty_victim) m_wb = sat(m_wb);
      m_hit = sat(m_hit);
    end
    @(negedge clk);
    chk_idle({name, "_after"});
    chk_counters(name);
    @(posedge clk); #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    //          rd  wr  hit    lru vv  vd  wb fill exp way
    tbl[0] = '{1'b1, 1'b0, 2'b10, 1'b0, 1'b1, 1'b0, 0, 0, 1, 1'b1};  // read hit way 1
    tbl[1] = '{1'b0, 1'b1, 2'b01, 1'b1, 1'b1, 1'b0, 0, 0, 1, 1'b0};  // write hit way 0
    tbl[2] = '{1'b1, 1'b1, 2'b10, 1'b0, 1'b1, 1'b0, 0, 0, 1, 1'b1};  // rd+wr acts as write
    tbl[3] = '{1'b1, 1'b0, 2'b11, 1'b0, 1'b1, 1'b0, 0, 0, 1, 1'b1};  // illegal 11 -> way 1
    tbl[4] = '{1'b1, 1'b0, 2'b00, 1'b1, 1'b1, 1'b0, 0, 5, 9, 1'b1};  // clean miss
    tbl[5] = '{1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 0, 0, 4, 1'b0};  // invalid victim: clean
    tbl[6] = '{1'b1, 1'b0, 2'b00, 1'b0, 1'b1, 1'b1, 3, 2, 10, 1'b0}; // dirty miss
    tbl[7] = '{1'b0, 1'b1, 2'b00, 1'b1, 1'b1, 1'b1, 0, 1, 6, 1'b1};  // dirty write miss

    rst = 1; mem_read = 0; mem_write = 0; hit = 0; lru = 0;
    victim_valid = 0; victim_dirty = 0; pmem_resp = 0;
    m_hit = '0; m_miss = '0; m_wb = '0;
    repeat (2) @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    chk_idle("reset");
    chk_counters("reset");
    @(posedge clk); #1;

    for (int i = 0; i < 8; i++) run_txn(tbl[i], $sformatf("vec%0d", i));

    // Reset while a fill is outstanding.
    mem_read = 1; hit = 0; lru = 1; victim_valid = 0; victim_dirty = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rstfill_pre_pmem_read", 32'(pmem_read), 32'd1);
    rst = 1; mem_read = 0;
    @(posedge clk); #1;
    rst = 0;
    @(negedge clk);
    chk("rstfill_pmem_read", 32'(pmem_read), 32'd0);
    chk("rstfill_loads", 32'({tag_load, valid_load, data_we}), 32'd0);
    m_hit = '0; m_miss = '0; m_wb = '0;
    chk_counters("rstfill");
    @(posedge clk); #1;

    // Saturation: more misses than a CW-bit counter can hold.
    for (int i = 0; i < 17; i++) run_txn(tbl[5], $sformatf("sat%0d", i));
    chk("sat_miss_ones", 32'(miss_count), 32'({CW{1'b1}}));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
